// File: rtl/led_blink_stretch_pkg.sv
// Shared definitions for the LED blink stretcher: per-channel FSM state
// encoding and width helpers used to size the channel counters.
package led_blink_stretch_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOn   = 2'd1;
  localparam logic [1:0] StOff  = 2'd2;

  // Bits needed to hold 0..v-1; never less than one so a counter always exists.
  function automatic int unsigned clog2_w(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: turns each tick into one fixed-length blink, queueing
// ticks that arrive mid-blink and replaying them after a dark gap.
module led_blink_ch
  import led_blink_stretch_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000,
  parameter int unsigned QMAX       = 7
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  output logic o_led
);

  localparam int unsigned CntW  = clog2_w(longint'(max_u(ON_CYCLES, OFF_CYCLES)));
  localparam int unsigned PendW = clog2_w(longint'(QMAX) + 64'd1);

  localparam logic [CntW-1:0]  CntOnLoad  = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0]  CntOffLoad = CntW'(OFF_CYCLES - 1);
  localparam logic [PendW-1:0] PendMax    = PendW'(QMAX);

  logic [1:0]       r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [PendW-1:0] r_pend, w_pend_d;
  logic [PendW-1:0] w_pend_inc;
  logic             r_led;

  // Saturating enqueue; ticks beyond QMAX are dropped.
  assign w_pend_inc = (r_pend == PendMax) ? r_pend : r_pend + 1'b1;

  // Next-state logic for the blink FSM, down-counter and pending queue.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pend_d  = r_pend;
    case (r_state)
      StIdle: begin
        if (i_tick) begin
          w_state_d = StOn;
          w_cnt_d   = CntOnLoad;
        end
      end
      StOn: begin
        if (r_cnt == '0) begin
          w_state_d = StOff;
          w_cnt_d   = CntOffLoad;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
        if (i_tick) w_pend_d = w_pend_inc;
      end
      StOff: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
          if (i_tick) w_pend_d = w_pend_inc;
        end else if (r_pend != '0) begin
          // Replaying a queued blink; a same-cycle tick takes its place in the queue.
          w_state_d = StOn;
          w_cnt_d   = CntOnLoad;
          if (!i_tick) w_pend_d = r_pend - 1'b1;
        end else if (i_tick) begin
          // Empty queue: the tick is consumed directly by the restart.
          w_state_d = StOn;
          w_cnt_d   = CntOnLoad;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_pend_d  = '0;
      end
    endcase
  end

  // State registers; the LED is registered from the next state so it tracks ON exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pend  <= w_pend_d;
      r_led   <= (w_state_d == StOn);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_blink_stretch.sv
// Top level: N_CH independent blink-stretch channels, one per button tick.
module led_blink_stretch
  import led_blink_stretch_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000,
  parameter int unsigned QMAX       = 7
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_tick,
  output logic [N_CH-1:0] o_leds
);

  // Channels share no state; each gets its own FSM, counter and queue.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_blink_ch #(
      .ON_CYCLES (ON_CYCLES),
      .OFF_CYCLES(OFF_CYCLES),
      .QMAX      (QMAX)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_tick (i_tick[g]),
      .o_led  (o_leds[g])
    );
  end

endmodule

// File: tb/tb_led_blink_stretch.sv
// Scoreboard bench: the stimulus process pushes the hand-computed LED vector
// for every cycle it drives; the monitor pops and compares at each falling edge.
module tb_led_blink_stretch;

  localparam int unsigned NCh   = 4;
  localparam int          NCyc  = 40;
  localparam int          NScen = 6;

  typedef struct {
    int         id;
    int         cyc;
    logic [3:0] leds;
  } exp_t;

  logic           i_clk;
  logic           i_rst_n;
  logic [NCh-1:0] i_tick;
  logic [NCh-1:0] o_leds;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  led_blink_stretch #(
    .N_CH      (NCh),
    .ON_CYCLES (4),
    .OFF_CYCLES(2),
    .QMAX      (3)
  ) u_dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tick (i_tick),
    .o_leds (o_leds)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Tick pattern per scenario and cycle.
  function automatic logic [3:0] tick_vec(input int id, input int c);
    logic [3:0] t;
    t = 4'b0000;
    case (id)
      0: t[0] = (c == 10) || (c == 17);
      1: t[0] = (c == 10) || (c == 12) || (c == 13);
      2: t[0] = rng(c, 10, 15);
      3: t[0] = (c == 10) || (c == 13);
      4: begin
        t[1] = (c == 20);
        t[3] = (c == 20);
      end
      5: t[0] = (c == 10) || (c == 16);
      default: t = 4'b0000;
    endcase
    return t;
  endfunction

  function automatic logic rst_val(input int id, input int c);
    return !((id == 3) && ((c == 12) || (c == 13)));
  endfunction

  // Hand-computed LED vectors with ON=4, OFF=2, QMAX=3.
  function automatic logic [3:0] exp_vec(input int id, input int c);
    logic [3:0] e;
    e = 4'b0000;
    case (id)
      0: e[0] = rng(c, 11, 14) || rng(c, 18, 21);
      1: e[0] = rng(c, 11, 14) || rng(c, 17, 20) || rng(c, 23, 26);
      2: e[0] = rng(c, 11, 14) || rng(c, 17, 20) || rng(c, 23, 26) || rng(c, 29, 32);
      3: e[0] = (c == 11);
      4: begin
        e[1] = rng(c, 21, 24);
        e[3] = rng(c, 21, 24);
      end
      5: e[0] = rng(c, 11, 14) || rng(c, 17, 20);
      default: e = 4'b0000;
    endcase
    return e;
  endfunction

  // Monitor: compare the DUT against the oldest expectation once per cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge i_clk);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        n_vec++;
        if (o_leds !== x.leds) begin
          n_err++;
          $display("FAIL leds scen=%0d cyc=%0d got=%b want=%b", x.id, x.cyc, o_leds, x.leds);
        end
      end
    end
  end

  // Stimulus: reset preamble then the directed tick pattern for each scenario.
  initial begin
    exp_t x;
    n_vec   = 0;
    n_err   = 0;
    i_rst_n = 1'b0;
    i_tick  = '0;
    for (int id = 0; id < NScen; id++) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        i_tick  = (k == 1) ? 4'b1111 : 4'b0000;
        x.id   = id;
        x.cyc  = -3 + k;
        x.leds = 4'b0000;
        sb.push_back(x);
      end
      for (int c = 0; c < NCyc; c++) begin
        @(posedge i_clk);
        #1;
        i_rst_n = rst_val(id, c);
        i_tick  = tick_vec(id, c);
        x.id   = id;
        x.cyc  = c;
        x.leds = exp_vec(id, c);
        sb.push_back(x);
      end
    end
    @(posedge i_clk);
    #1;
    i_tick = '0;
    for (int w = 0; w < 4 && sb.size() != 0; w++) @(posedge i_clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_blink_stretch.md
# led_blink_stretch

Converts single-cycle button ticks back into human-visible LED blinks, one channel per button. It sits between the edge-detect stage and the board LEDs, replacing the direct tick-to-LED wiring. Each tick yields exactly one blink of fixed length, and ticks arriving during a blink are queued and replayed as separate blinks, so every press is visible.

## Interface
- N_CH, 4: number of independent channels.
- ON_CYCLES, 25_000_000: cycles LED is lit per blink; must be ≥1.
- OFF_CYCLES, 12_500_000: dark gap between queued blinks; must be ≥1.
- QMAX, 7: maximum queued (pending) blinks per channel; must be ≥1.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- tick  in  N_CH  one-cycle pulses from edge detectors; multi-cycle high counts as one tick per cycle.
- leds  out  N_CH  LED drive, active-high, registered.

## Operation
Per channel, independent FSM with three states, down-counter `cnt`, and saturating counter `pend` (0..QMAX):
- IDLE: led=0. tick → ON, cnt=ON_CYCLES-1.
- ON: led=1. cnt==0 → OFF, cnt=OFF_CYCLES-1; else cnt--.
- OFF: led=0. cnt!=0 → cnt--. cnt==0 with pend>0 or tick → ON, cnt=ON_CYCLES-1; else → IDLE.
- Tick while in ON or OFF and not consumed by the OFF→ON transition: pend++, saturating at QMAX. Ticks beyond saturation are dropped silently.
- OFF→ON with pend>0: pend--. If a tick arrives the same cycle, it is added to the queue, so pend stays unchanged.
- OFF→ON with pend==0 and a tick: the tick is consumed directly and pend stays 0.
- tick in IDLE never touches pend.
- Reset (any time, including mid-blink): all channels go to IDLE, cnt=0, pend=0, leds=0. Nothing queued survives reset.

## Timing
- A tick high in cycle t produces an LED rising edge at the clock edge ending cycle t. LED is high in cycles t+1 .. t+ON_CYCLES.
- Blink period when queued: ON_CYCLES high followed by OFF_CYCLES low. The next blink starts at cycle t+ON_CYCLES+OFF_CYCLES+1.
- After the last blink, the FSM re-enters IDLE one cycle after OFF ends. A tick in that IDLE cycle starts ON the following cycle, with no additional gap.
- leds deassert asynchronously when reset goes low. They stay 0 until the first tick after reset releases.
- Channels share no state. Simultaneous ticks on several channels are all honoured in the same cycle.
- Width of cnt is clog2(max(ON_CYCLES, OFF_CYCLES)). Width of pend is clog2(QMAX+1). No wrap-around is allowed.

## Structure
- Shared package holds: the state encoding localparams (IDLE=2'd0, ON=2'd1, OFF=2'd2) and a clog2 width function.
- Sub-module `led_blink_ch`: one channel (FSM, cnt, pend), parameterised by ON_CYCLES/OFF_CYCLES/QMAX.
- The top level instantiates N_CH copies in a generate loop. Unreachable state 2'd3 recovers to IDLE.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=2, QMAX=3, with the tick on channel 0 unless noted.
- Single tick in cycle 10 → leds[0]=1 in cycles 11–14, 0 from cycle 15. FSM in IDLE by cycle 17.
- Ticks in cycles 10, 12, 13 → four... corrected: three blinks total. High 11–14, 17–20, 23–26; low in the gaps.
- Ticks in cycles 10, 11, 12, 13, 14, 15 → pend saturates at 3. Exactly 4 blinks; the 5th and 6th ticks are dropped.
- Tick in cycle 10, reset low in cycle 12 for 2 cycles, tick during reset → leds[0]=0 immediately. No blink resumes after release.
- Ticks on ch1 and ch3 in cycle 20 → leds=4'b1010 in cycles 21–24. Ch0 and ch2 stay 0.
- Tick in cycle 10, then a second tick in cycle 16 (last OFF cycle, pend=0) → second blink high 17–20, consumed directly, pend stays 0.
